// File: rtl/beta_encoder.sv
// beta_encoder: reassembles RV32I instruction words from decoded field bundles into an output FIFO.
// Define BETA_ENCODER_STATS_EN to add saturating accepted-bundle and error-word counters.
module beta_encoder #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [8:0]                 cu_addr_i,
  input  logic [4:0]                 rs1_i,
  input  logic [4:0]                 rs2_i,
  input  logic [4:0]                 rd_i,
  input  logic [11:0]                imm12_i,
  input  logic [19:0]                imm20_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [XLEN-1:0]            instr_o,
  output logic                       err_o,
  output logic [$clog2(DEPTH):0]     level_o
`ifdef BETA_ENCODER_STATS_EN
  ,
  output logic [31:0]                enc_cnt_o,
  output logic [15:0]                err_cnt_o
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [4:0] op;
  logic [2:0] f3;
  logic [XLEN-1:0] enc_word, s1_word;
  logic enc_err, s1_v, s1_err, accept, pop;
  logic [XLEN:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] cnt, level_nxt;
  assign op = cu_addr_i[8:4];
  assign f3 = cu_addr_i[3:1];
  always_comb begin
    enc_err = 1'b0;
    enc_word = {7'b0, rs2_i, rs1_i, f3, rd_i, op, 2'b11};
    case (op)
      5'b00100: enc_word[31:20] = (f3 == 3'd1 || f3 == 3'd5) ? {1'b0, cu_addr_i[0], 5'b0, imm12_i[4:0]} : imm12_i;
      5'b01100: enc_word[31:25] = {1'b0, cu_addr_i[0], 5'b0};
      5'b01101, 5'b00101: enc_word[31:12] = imm20_i;
      5'b11011: enc_word[31:12] = {imm20_i[19], imm20_i[9:0], imm20_i[10], imm20_i[18:11]};
      5'b11001, 5'b00000, 5'b11100: enc_word[31:20] = imm12_i;
      5'b11000: begin
        enc_word[31]    = imm12_i[11];
        enc_word[30:25] = imm12_i[9:4];
        enc_word[11:8]  = imm12_i[3:0];
        enc_word[7]     = imm12_i[10];
      end
      5'b01000: begin
        enc_word[31:25] = imm12_i[11:5];
        enc_word[11:7]  = imm12_i[4:0];
      end
      5'b00011: enc_word[31:20] = 12'h000;
      default: enc_err = 1'b1;
    endcase
    if (cu_addr_i == 9'h1FF) enc_err = 1'b1;
    if (enc_err) enc_word = '0;
  end
  assign accept      = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;
  assign out_valid_o = cnt != '0;
  assign {err_o, instr_o} = out_valid_o ? mem[rd_ptr] : '0;
  // the word waiting in stage 1 already owns a slot, so the FIFO can never overflow
  assign level_o   = cnt + LW'(s1_v);
  assign level_nxt = level_o + LW'(accept) - LW'(pop);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_v       <= 1'b0;
      s1_err     <= 1'b0;
      s1_word    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      in_ready_o <= 1'b0;
    end else begin
      s1_v       <= accept;
      if (accept) {s1_err, s1_word} <= {enc_err, enc_word};
      wr_ptr     <= wr_ptr + AW'(s1_v);
      rd_ptr     <= rd_ptr + AW'(pop);
      cnt        <= cnt + LW'(s1_v) - LW'(pop);
      in_ready_o <= level_nxt < LW'(DEPTH);
    end
  end
  always_ff @(posedge clk_i) if (s1_v) mem[wr_ptr] <= {s1_err, s1_word};
`ifdef BETA_ENCODER_STATS_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      enc_cnt_o <= '0;
      err_cnt_o <= '0;
    end else if (accept) begin
      enc_cnt_o <= enc_cnt_o + 32'(enc_cnt_o != '1);
      err_cnt_o <= err_cnt_o + 16'(enc_err && err_cnt_o != '1);
    end
  end
`endif
endmodule

// File: tb/tb_beta_encoder.sv
// tb_beta_encoder: directed and randomized checks of beta_encoder against a format-level RV32I model.
module tb_beta_encoder;
  localparam int DEPTH = 2;
  logic clk = 1'b0, rst, in_valid, in_ready, out_valid, out_ready, err;
  logic [8:0] cu;
  logic [4:0] rs1, rs2, rd;
  logic [11:0] imm12;
  logic [19:0] imm20;
  logic [31:0] instr;
  logic [$clog2(DEPTH):0] level;
`ifdef BETA_ENCODER_STATS_EN
  logic [31:0] enc_cnt;
  logic [15:0] err_cnt;
`endif
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;

  beta_encoder #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .cu_addr_i(cu), .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .imm12_i(imm12), .imm20_i(imm20),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .instr_o(instr), .err_o(err), .level_o(level)
`ifdef BETA_ENCODER_STATS_EN
    , .enc_cnt_o(enc_cnt), .err_cnt_o(err_cnt)
`endif
  );

  logic [8:0]  d_cu  [5] = '{9'h040, 9'h0C1, 9'h04B, 9'h1B0, 9'h180};
  logic [4:0]  d_rs1 [5] = '{5'd2, 5'd1, 5'd5, 5'd0, 5'd1};
  logic [4:0]  d_rs2 [5] = '{5'd0, 5'd2, 5'd0, 5'd0, 5'd2};
  logic [4:0]  d_rd  [5] = '{5'd1, 5'd3, 5'd5, 5'd1, 5'd0};
  logic [11:0] d_i12 [5] = '{12'h005, 12'h000, 12'h403, 12'h000, 12'h004};
  logic [19:0] d_i20 [5] = '{20'h0, 20'h0, 20'h0, 20'h00004, 20'h0};
  logic [31:0] d_exp [5] = '{32'h00510093, 32'h402081B3, 32'h4032D293, 32'h008000EF, 32'h00208463};
  logic [4:0]  ops   [11] = '{5'd0, 5'd3, 5'd4, 5'd5, 5'd8, 5'd12, 5'd13, 5'd24, 5'd25, 5'd27, 5'd28};

  // Model works from RISC-V byte offsets (imm * 2) and standard B/J/S/I/U/R packing
  function automatic logic [32:0] ref_enc(input logic [8:0] c, input logic [4:0] a, b, d,
                                          input logic [11:0] i12, input logic [19:0] i20);
    logic [31:0] op, f3, f7, r1, r2, t, w;
    logic [12:0] bo;
    logic [20:0] jo;
    op = {25'd0, c[8:4], 2'b11};
    f3 = 32'(c[3:1]);
    f7 = c[0] ? 32'h20 : 32'h0;
    r1 = 32'(a);
    r2 = 32'(b);
    bo = {i12, 1'b0};
    jo = {i20, 1'b0};
    t  = r1 << 15 | f3 << 12 | 32'(d) << 7 | op;
    if (c == 9'h1FF) return {1'b1, 32'h0};
    case (op)
      32'h33: w = f7 << 25 | r2 << 20 | t;
      32'h13: w = (f3 == 1 || f3 == 5) ? (f7 << 25 | 32'(i12[4:0]) << 20 | t) : (32'(i12) << 20 | t);
      32'h03, 32'h67, 32'h73: w = 32'(i12) << 20 | t;
      32'h0F: w = t;
      32'h37, 32'h17: w = 32'(i20) << 12 | 32'(d) << 7 | op;
      32'h6F: w = 32'(jo[20]) << 31 | 32'(jo[10:1]) << 21 | 32'(jo[11]) << 20 | 32'(jo[19:12]) << 12 | 32'(d) << 7 | op;
      32'h63: w = 32'(bo[12]) << 31 | 32'(bo[10:5]) << 25 | r2 << 20 | r1 << 15 | f3 << 12 | 32'(bo[4:1]) << 8 | 32'(bo[11]) << 7 | op;
      32'h23: w = 32'(i12[11:5]) << 25 | r2 << 20 | r1 << 15 | f3 << 12 | 32'(i12[4:0]) << 7 | op;
      default: return {1'b1, 32'h0};
    endcase
    return {1'b0, w};
  endfunction

  task automatic drive(input int i);
    in_valid = 1'b1; cu = d_cu[i]; rs1 = d_rs1[i]; rs2 = d_rs2[i]; rd = d_rd[i]; imm12 = d_i12[i]; imm20 = d_i20[i];
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    cu = '0; rs1 = '0; rs2 = '0; rd = '0; imm12 = '0; imm20 = '0;
    repeat (2) @(negedge clk);
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    n_chk++; if (instr !== 32'h0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_word got %h/%b exp 0/0", instr, err); end
    n_chk++; if (level !== '0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", level); end
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_directed;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(i);
      @(negedge clk);
      in_valid = 1'b0;
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dir%0d_early got %b exp 0", i, out_valid); end
      @(negedge clk);
      n_chk++; if (out_valid !== 1'b1 || instr !== d_exp[i] || err !== 1'b0)
        begin n_fail++; $display("FAIL dir%0d_word got v%b %h e%b exp v1 %h e0", i, out_valid, instr, err, d_exp[i]); end
      @(negedge clk);
      n_chk++; if (out_valid !== 1'b0 || level !== '0) begin n_fail++; $display("FAIL dir%0d_drain got v%b l%0d exp v0 l0", i, out_valid, level); end
    end
  endtask

  task automatic test_errors;
    out_ready = 1'b0;
    drive(0); cu = 9'h1FF;
    @(negedge clk);
    cu = 9'h070;
    @(negedge clk);
    in_valid = 1'b0;
    n_chk++; if (level !== 2 || in_ready !== 1'b0) begin n_fail++; $display("FAIL err_full got l%0d r%b exp l2 r0", level, in_ready); end
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b1 || instr !== 32'h0 || err !== 1'b1) begin n_fail++; $display("FAIL err_word1 got v%b %h e%b exp v1 0 e1", out_valid, instr, err); end
    out_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (level !== 1 || instr !== 32'h0 || err !== 1'b1) begin n_fail++; $display("FAIL err_word2 got l%0d %h e%b exp l1 0 e1", level, instr, err); end
    @(negedge clk);
    n_chk++; if (level !== 0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL err_drain got l%0d v%b exp l0 v0", level, out_valid); end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b0;
    drive(0);
    @(negedge clk);
    drive(1);
    @(negedge clk);
    drive(2);
    for (int c = 0; c < 3; c++) begin
      n_chk++; if (in_ready !== 1'b0 || level !== 2) begin n_fail++; $display("FAIL bp_stall%0d got r%b l%0d exp r0 l2", c, in_ready, level); end
      if (c > 0) begin
        n_chk++; if (instr !== d_exp[0] || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold%0d got v%b %h exp v1 %h", c, out_valid, instr, d_exp[0]); end
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (instr !== d_exp[1] || in_ready !== 1'b1 || level !== 1) begin n_fail++; $display("FAIL bp_second got %h r%b l%0d exp %h r1 l1", instr, in_ready, level, d_exp[1]); end
    @(negedge clk);
    in_valid = 1'b0;
    n_chk++; if (out_valid !== 1'b0 || level !== 1) begin n_fail++; $display("FAIL bp_stage got v%b l%0d exp v0 l1", out_valid, level); end
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b1 || instr !== d_exp[2]) begin n_fail++; $display("FAIL bp_third got v%b %h exp v1 %h", out_valid, instr, d_exp[2]); end
    @(negedge clk);
    n_chk++; if (level !== 0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got l%0d v%b exp l0 v0", level, out_valid); end
  endtask

  task automatic test_random;
    logic [32:0] fq[$];
    logic [32:0] pend, e;
    bit pend_v = 0, acc, pp;
    int lvl, enc_m = 0, err_m = 0;
    for (int c = 0; c < 600; c++) begin
      lvl = fq.size() + int'(pend_v);
      n_chk++; if (in_ready !== (lvl < DEPTH) || level !== lvl) begin n_fail++; $display("FAIL rnd_level c%0d got r%b l%0d exp r%0d l%0d", c, in_ready, level, lvl < DEPTH, lvl); end
      n_chk++; if (out_valid !== (fq.size() != 0)) begin n_fail++; $display("FAIL rnd_valid c%0d got %b exp %0d", c, out_valid, fq.size() != 0); end
      if (fq.size() != 0) begin
        n_chk++; if ({err, instr} !== fq[0]) begin n_fail++; $display("FAIL rnd_word c%0d got %b %h exp %b %h", c, err, instr, fq[0][32], fq[0][31:0]); end
      end
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = (c >= 590) || ($urandom_range(0, 2) != 0);
      if (c >= 585) in_valid = 1'b0;
      cu = ($urandom_range(0, 4) == 0) ? 9'($urandom) : {ops[$urandom_range(0, 10)], 3'($urandom), 1'($urandom)};
      rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom);
      imm12 = 12'($urandom); imm20 = 20'($urandom);
      e = ref_enc(cu, rs1, rs2, rd, imm12, imm20);
      acc = in_valid && (lvl < DEPTH);
      pp = (fq.size() != 0) && out_ready;
      @(posedge clk);
      if (pp) void'(fq.pop_front());
      if (pend_v) fq.push_back(pend);
      pend_v = acc;
      if (acc) begin pend = e; enc_m++; err_m += int'(e[32]); end
      @(negedge clk);
    end
    n_chk++; if (level !== 0 || fq.size() != 0 || pend_v) begin n_fail++; $display("FAIL rnd_drain got l%0d exp 0 (model %0d)", level, fq.size()); end
`ifdef BETA_ENCODER_STATS_EN
    n_chk++; if (enc_cnt !== 32'(enc_m) || err_cnt !== 16'(err_m)) begin n_fail++; $display("FAIL rnd_stats got %0d/%0d exp %0d/%0d", enc_cnt, err_cnt, enc_m, err_m); end
`endif
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    drive(0);
    @(negedge clk);
    drive(1);
    @(negedge clk);
    in_valid = 1'b0;
    n_chk++; if (level !== 2) begin n_fail++; $display("FAIL mid_fill got l%0d exp 2", level); end
    #2 rst = 1'b1;
    #1;
    n_chk++; if (out_valid !== 1'b0 || level !== 0 || instr !== 32'h0) begin n_fail++; $display("FAIL mid_rst got v%b l%0d %h exp v0 l0 0", out_valid, level, instr); end
`ifdef BETA_ENCODER_STATS_EN
    n_chk++; if (enc_cnt !== 0 || err_cnt !== 0) begin n_fail++; $display("FAIL mid_stats got %0d/%0d exp 0/0", enc_cnt, err_cnt); end
`endif
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || level !== 0) begin n_fail++; $display("FAIL mid_after got r%b v%b l%0d exp r1 v0 l0", in_ready, out_valid, level); end
  endtask

  initial begin
    test_reset;
    test_random;
    test_directed;
    test_errors;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
